access_control_param: RTL and testbench

- Parametrised password checker for the lock front end. It collects a multi-digit password one digit per load strobe for a selected user and compares it against a per-user stored table.
- Reports granted or denied status. Counts consecutive failures and forces a timed lockout after too many.
- Sits between the keypad/debounce path and the LED/display status logic.

---
 rtl/access_control_param.sv | 175 +++++++++++++++++
 tb/tb_access_control_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/access_control_param.sv
// access_control_param
// Password checker for the lock front end. A login selects a user, then one
// digit is collected per load strobe and compared against that user's stored
// code. Every digit is compared whether or not an earlier one already missed,
// so a denial takes the same time wherever the wrong digit was. Consecutive
// failures are counted, and the lock is forced into a timed lockout once the
// count reaches MAX_FAILS.
module access_control_param #(
   parameter int DIGIT_W        = 4,
   parameter int NUM_DIGITS     = 4,
   parameter int NUM_USERS      = 4,
   parameter logic [NUM_USERS*NUM_DIGITS*DIGIT_W-1:0] PASSWORDS = 64'h9999_0000_5440_1476,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int ENTRY_TIMEOUT  = 5000,
   localparam int UID_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
   localparam int FC_W  = $clog2(MAX_FAILS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_login,
   input  logic               req_logout,
   input  logic [UID_W-1:0]   user_id,
   input  logic [DIGIT_W-1:0] digit_in,
   input  logic               digit_load,
   output logic [1:0]         status,
   output logic               granted,
   output logic               locked,
   output logic [FC_W-1:0]    fail_count
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int TO_W  = $clog2(ENTRY_TIMEOUT + 1);
   localparam int LK_W  = $clog2(LOCKOUT_CYCLES + 1);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ENTRY_TIMEOUT - 1);
   localparam logic [LK_W-1:0]  LK_LAST  = LK_W'(LOCKOUT_CYCLES - 1);
   localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAILS);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_CHECK   = 3'd2;
   localparam logic [2:0] S_GRANTED = 3'd3;
   localparam logic [2:0] S_DENIED  = 3'd4;
   localparam logic [2:0] S_LOCKED  = 3'd5;

   logic [2:0]         state;
   logic [UID_W-1:0]   user_q;
   logic [IDX_W-1:0]   idx_q;
   logic               mismatch_q;
   logic [TO_W-1:0]    to_cnt;
   logic [LK_W-1:0]    lock_cnt;
   logic [DIGIT_W-1:0] stored_digit;
   logic               uid_valid;

   logic [DIGIT_W-1:0] pw_table [NUM_USERS][NUM_DIGITS];

   // Unpack the flat password word into [user][digit]; digit 0 is the most
   // significant digit of each user's word, i.e. the first one typed.
   for (genvar u = 0; u < NUM_USERS; u++) begin : g_user
      for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
         assign pw_table[u][d] = PASSWORDS[(u*NUM_DIGITS + (NUM_DIGITS-1-d))*DIGIT_W +: DIGIT_W];
      end
   end

   // Look up the digit expected at the current position for the latched user.
   always_comb begin
      stored_digit = pw_table[user_q][idx_q];
      uid_valid    = (int'(user_id) < NUM_USERS);
   end

   // Main FSM together with its digit index, mismatch flag, timers and
   // failure counter. An invalid user is latched as user 0 with the mismatch
   // flag already set, so the attempt still runs the full digit count and
   // is then denied.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         user_q     <= '0;
         idx_q      <= '0;
         mismatch_q <= 1'b0;
         to_cnt     <= '0;
         lock_cnt   <= '0;
         fail_count <= '0;
      end else begin
         case (state)
            S_IDLE, S_DENIED: begin
               if (req_logout) begin
                  state <= S_IDLE;
               end else if (req_login) begin
                  state  <= S_COLLECT;
                  idx_q  <= '0;
                  to_cnt <= '0;
                  if (uid_valid) begin
                     user_q     <= user_id;
                     mismatch_q <= 1'b0;
                  end else begin
                     user_q     <= '0;
                     mismatch_q <= 1'b1;
                  end
               end
            end
            S_COLLECT: begin
               if (req_logout) begin
                  state <= S_IDLE;
               end else if (digit_load) begin
                  mismatch_q <= mismatch_q | (digit_in != stored_digit);
                  to_cnt     <= '0;
                  if (idx_q == IDX_LAST) begin
                     idx_q <= '0;
                     state <= S_CHECK;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else if (to_cnt == TO_LAST) begin
                  mismatch_q <= 1'b1;
                  state      <= S_CHECK;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_CHECK: begin
               if (!mismatch_q) begin
                  state      <= S_GRANTED;
                  fail_count <= '0;
               end else if (int'(fail_count) + 1 == MAX_FAILS) begin
                  state      <= S_LOCKED;
                  fail_count <= FC_MAX;
                  lock_cnt   <= '0;
               end else begin
                  state      <= S_DENIED;
                  fail_count <= fail_count + 1'b1;
               end
            end
            S_GRANTED: begin
               if (req_logout) begin
                  state <= S_IDLE;
               end
            end
            S_LOCKED: begin
               if (lock_cnt == LK_LAST) begin
                  state      <= S_IDLE;
                  fail_count <= '0;
                  lock_cnt   <= '0;
               end else begin
                  lock_cnt <= lock_cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Status outputs are decoded straight from the state register, so they
   // change only on a clock edge or on reset.
   always_comb begin
      status  = 2'b00;
      granted = 1'b0;
      locked  = 1'b0;
      case (state)
         S_COLLECT, S_CHECK: status = 2'b01;
         S_GRANTED: begin
            status  = 2'b10;
            granted = 1'b1;
         end
         S_DENIED:  status = 2'b11;
         S_LOCKED:  locked = 1'b1;
         default:   status = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_access_control_param.sv
// tb_access_control_param
// Directed bench for the password checker. A second instance with
// NUM_USERS=3 shares the same stimulus and is checked for the out-of-range
// user case.
module tb_access_control_param;

   logic       clk;
   logic       rst;
   logic       req_login;
   logic       req_logout;
   logic [1:0] user_id;
   logic [3:0] digit_in;
   logic       digit_load;

   logic [1:0] status;
   logic       granted;
   logic       locked;
   logic [1:0] fail_count;

   logic [1:0] status3;
   logic       granted3;
   logic       locked3;
   logic [1:0] fail_count3;

   int checks;
   int errors;

   access_control_param #(
      .LOCKOUT_CYCLES(16),
      .ENTRY_TIMEOUT (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_login (req_login),
      .req_logout(req_logout),
      .user_id   (user_id),
      .digit_in  (digit_in),
      .digit_load(digit_load),
      .status    (status),
      .granted   (granted),
      .locked    (locked),
      .fail_count(fail_count)
   );

   access_control_param #(
      .NUM_USERS     (3),
      .PASSWORDS     (48'h0000_5440_1476),
      .LOCKOUT_CYCLES(16),
      .ENTRY_TIMEOUT (32)
   ) dut3 (
      .clk       (clk),
      .rst       (rst),
      .req_login (req_login),
      .req_logout(req_logout),
      .user_id   (user_id),
      .digit_in  (digit_in),
      .digit_load(digit_load),
      .status    (status3),
      .granted   (granted3),
      .locked    (locked3),
      .fail_count(fail_count3)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, step past the edge, then drop the pulses.
   task automatic applyStimulus(input logic login, input logic logout, input logic [1:0] uid,
                                input logic [3:0] digit, input logic load);
      req_login  = login;
      req_logout = logout;
      user_id    = uid;
      digit_in   = digit;
      digit_load = load;
      @(posedge clk);
      #1;
      req_login  = 1'b0;
      req_logout = 1'b0;
      digit_load = 1'b0;
   endtask

   // Idle cycles with no requests or loads.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
   endtask

   // Load the first 'count' digits of a 4-digit code, most significant first.
   task automatic loadCode(input logic [15:0] code, input int count);
      logic [15:0] sh;
      for (int i = 0; i < count; i++) begin
         sh = code << (4 * i);
         applyStimulus(1'b0, 1'b0, 2'd0, sh[15:12], 1'b1);
      end
   endtask

   // Compare all outputs of the main instance against expected values.
   task automatic checkOutput(input string tag, input logic [1:0] exp_status, input logic exp_granted,
                              input logic exp_locked, input logic [1:0] exp_fc);
      checks++;
      assert (status === exp_status) else begin
         errors++;
         $error("[TB] FAIL %s status observed=%b expected=%b", tag, status, exp_status);
      end
      checks++;
      assert (granted === exp_granted) else begin
         errors++;
         $error("[TB] FAIL %s granted observed=%b expected=%b", tag, granted, exp_granted);
      end
      checks++;
      assert (locked === exp_locked) else begin
         errors++;
         $error("[TB] FAIL %s locked observed=%b expected=%b", tag, locked, exp_locked);
      end
      checks++;
      assert (fail_count === exp_fc) else begin
         errors++;
         $error("[TB] FAIL %s fail_count observed=%0d expected=%0d", tag, fail_count, exp_fc);
      end
   endtask

   // Directed sequence
   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      req_login  = 1'b0;
      req_logout = 1'b0;
      user_id    = 2'd0;
      digit_in   = 4'd0;
      digit_load = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("reset", 2'b00, 1'b0, 1'b0, 2'd0);
      rst = 1'b0;
      idleCycles(1);

      $display("[TB] wrong digit on user 1");
      applyStimulus(1'b1, 1'b0, 2'd1, 4'd0, 1'b0);
      loadCode(16'h5441, 4);
      checkOutput("wrong1_check", 2'b01, 1'b0, 1'b0, 2'd0);
      idleCycles(1);
      checkOutput("wrong1_denied", 2'b11, 1'b0, 1'b0, 2'd1);

      $display("[TB] async reset mid entry");
      applyStimulus(1'b1, 1'b0, 2'd1, 4'd0, 1'b0);
      loadCode(16'h5440, 2);
      checkOutput("midentry", 2'b01, 1'b0, 1'b0, 2'd1);
      rst = 1'b1;
      #2;
      checkOutput("async_reset", 2'b00, 1'b0, 1'b0, 2'd0);
      rst = 1'b0;
      idleCycles(1);

      $display("[TB] correct entry user 0");
      applyStimulus(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
      loadCode(16'h1476, 4);
      checkOutput("user0_check", 2'b01, 1'b0, 1'b0, 2'd0);
      idleCycles(1);
      checkOutput("user0_granted", 2'b10, 1'b1, 1'b0, 2'd0);
      applyStimulus(1'b1, 1'b0, 2'd1, 4'd1, 1'b1);
      checkOutput("granted_ignores", 2'b10, 1'b1, 1'b0, 2'd0);
      applyStimulus(1'b0, 1'b1, 2'd0, 4'd0, 1'b0);
      checkOutput("user0_logout", 2'b00, 1'b0, 1'b0, 2'd0);

      $display("[TB] user 1 wrong then right");
      applyStimulus(1'b1, 1'b0, 2'd1, 4'd0, 1'b0);
      loadCode(16'h5441, 4);
      idleCycles(1);
      checkOutput("user1_denied", 2'b11, 1'b0, 1'b0, 2'd1);
      applyStimulus(1'b1, 1'b0, 2'd1, 4'd0, 1'b0);
      loadCode(16'h5440, 4);
      idleCycles(1);
      checkOutput("user1_granted", 2'b10, 1'b1, 1'b0, 2'd0);
      applyStimulus(1'b0, 1'b1, 2'd0, 4'd0, 1'b0);

      $display("[TB] lockout on user 2");
      for (int a = 0; a < 2; a++) begin
         applyStimulus(1'b1, 1'b0, 2'd2, 4'd0, 1'b0);
         loadCode(16'h1111, 4);
         idleCycles(1);
      end
      checkOutput("lock_second_denied", 2'b11, 1'b0, 1'b0, 2'd2);
      applyStimulus(1'b1, 1'b0, 2'd2, 4'd0, 1'b0);
      loadCode(16'h1111, 4);
      idleCycles(1);
      checkOutput("locked", 2'b00, 1'b0, 1'b1, 2'd3);
      applyStimulus(1'b1, 1'b0, 2'd0, 4'd1, 1'b1);
      checkOutput("locked_ignores_login", 2'b00, 1'b0, 1'b1, 2'd3);
      idleCycles(13);
      checkOutput("locked_still", 2'b00, 1'b0, 1'b1, 2'd3);
      idleCycles(3);
      checkOutput("lock_released", 2'b00, 1'b0, 1'b0, 2'd0);

      $display("[TB] entry timeout on user 3");
      applyStimulus(1'b1, 1'b0, 2'd3, 4'd0, 1'b0);
      loadCode(16'h9999, 2);
      idleCycles(30);
      checkOutput("timeout_waiting", 2'b01, 1'b0, 1'b0, 2'd0);
      idleCycles(10);
      checkOutput("timeout_denied", 2'b11, 1'b0, 1'b0, 2'd1);

      $display("[TB] login and logout together from denied");
      applyStimulus(1'b1, 1'b1, 2'd0, 4'd0, 1'b0);
      checkOutput("logout_wins", 2'b00, 1'b0, 1'b0, 2'd1);

      $display("[TB] digit load alongside login");
      applyStimulus(1'b1, 1'b0, 2'd0, 4'd1, 1'b1);
      loadCode(16'h1476, 3);
      idleCycles(1);
      checkOutput("login_digit_dropped", 2'b01, 1'b0, 1'b0, 2'd1);
      applyStimulus(1'b0, 1'b0, 2'd0, 4'd6, 1'b1);
      idleCycles(1);
      checkOutput("login_digit_granted", 2'b10, 1'b1, 1'b0, 2'd0);
      applyStimulus(1'b0, 1'b1, 2'd0, 4'd0, 1'b0);

      $display("[TB] user 3 against a three-user table");
      rst = 1'b1;
      idleCycles(1);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 2'd3, 4'd0, 1'b0);
      loadCode(16'h9999, 4);
      idleCycles(1);
      checkOutput("four_users_user3", 2'b10, 1'b1, 1'b0, 2'd0);
      checks++;
      assert (status3 === 2'b11) else begin
         errors++;
         $error("[TB] FAIL three_users_status observed=%b expected=%b", status3, 2'b11);
      end
      checks++;
      assert (fail_count3 === 2'd1) else begin
         errors++;
         $error("[TB] FAIL three_users_fail_count observed=%0d expected=%0d", fail_count3, 2'd1);
      end
      checks++;
      assert (granted3 === 1'b0 && locked3 === 1'b0) else begin
         errors++;
         $error("[TB] FAIL three_users_flags observed=%b%b expected=00", granted3, locked3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
